uart_rx: RTL

- 8N1 UART receiver, the receive-side counterpart of the existing uart_tx.
- Gives the SoC a host-to-core serial path, for example for loading programs or sending commands.
- Sits beside uart_tx at top level; its byte output is later memory-mapped for the core to poll.
- Samples each bit at mid-bit, delivers the byte over a valid/ready hold register, and flags framing and overrun errors.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 31 +++
 rtl/uart_rx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// bit-period helper. Intended to be shared with uart_tx as well.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  // Clock cycles per serial bit, truncating integer division.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset (both flops reset to RESET_VAL)
//   d     - asynchronous input
//   q     - synchronised output, two cycles behind d
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a valid/ready hold register,
// a framing-error pulse and a sticky overrun flag.
// Optional build macro: UART_RX_MAJORITY_EN selects 2-of-3 majority sampling
// around each sample point (decision one cycle after the nominal point).
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   rx           - asynchronous serial input, idle high
//   data         - received byte, stable while data_valid is high
//   data_valid   - data holds an unconsumed byte
//   data_ready   - consumer accepts the byte
//   frame_err    - one-cycle pulse when a stop bit is sampled low
//   overrun      - sticky, a byte was dropped because the hold register was full
//   overrun_clr  - clears overrun (a simultaneous set wins)
//   busy         - a frame is in progress
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 95_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned BIT_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] START_PT = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_PT   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 8) begin : gen_cfg_err
    $error("uart_rx: CLK_FREQ/BAUD must be at least 8");
  end

  logic rx_s;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;

  logic [CNT_W-1:0] nom_pt;
  logic             decide;
  logic             sample;
  logic [CNT_W-1:0] reload;
  logic             good_stop;
  logic             bad_stop;

  assign nom_pt = (state_q == START) ? START_PT : BIT_PT;

`ifdef UART_RX_MAJORITY_EN
  logic vote0_q, vote1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vote0_q <= 1'b1;
      vote1_q <= 1'b1;
    end else begin
      if (cnt_q == nom_pt - CNT_W'(1)) vote0_q <= rx_s;
      if (cnt_q == nom_pt)             vote1_q <= rx_s;
    end
  end

  assign decide = (cnt_q == nom_pt + CNT_W'(1));
  assign sample = (vote0_q & vote1_q) | (vote0_q & rx_s) | (vote1_q & rx_s);
  // The decision lands one cycle past the nominal point, so restart at 1 to
  // keep the spacing between sample points equal to CLKS_PER_BIT.
  assign reload = CNT_W'(1);
`else
  assign decide = (cnt_q == nom_pt);
  assign sample = rx_s;
  assign reload = '0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (decide) begin
          if (!sample) begin
            state_d = DATA;
            cnt_d   = reload;
          end else begin
            // Start bit vanished before its midpoint: a glitch.
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (decide) begin
          cnt_d   = reload;
          shift_d = {sample, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (decide) begin
          cnt_d = '0;
          if (sample) begin
            good_stop = 1'b1;
            state_d   = IDLE;
          end else begin
            bad_stop = 1'b1;
            state_d  = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BREAK: begin
        // Wait out a held-low line so it cannot retrigger a start.
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    fe_d    = bad_stop;
    if (valid_q && data_ready) valid_d = 1'b0;
    if (good_stop) begin
      if (!valid_q || data_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (good_stop && valid_q && !data_ready) begin
      ovr_d = 1'b1;
    end else if (overrun_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign frame_err  = fe_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule
